// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg -- shared types and constants for the data-memory arbiter.
// Holds the arbiter FSM state encoding and the word alignment / bounds
// check used to reject a transaction before it reaches memory.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Offset of the last byte of a word relative to its start address.
    localparam int unsigned WORD_LAST_OFS = 3;

    // True when a word access at addr is misaligned or runs past the memory.
    // The sum is widened to 33 bits so addresses near 2^32 cannot wrap.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input int unsigned mem_bytes);
        logic [32:0] last_byte;
        last_byte = {1'b0, addr} + 33'(WORD_LAST_OFS);
        return ((addr[1:0] & ALIGN_MASK) != 2'b00) ||
               (last_byte >= 33'(mem_bytes));
    endfunction

endpackage

// File: rtl/dmem_arbiter_arb2.sv
// arb2 -- two-way request arbiter.
// Default build: fixed priority, port 0 wins simultaneous requests.
// Define DMEM_ARB_RR_EN for round-robin: on a tie the port not granted
// last wins, and the pointer moves on every accepted grant.
module arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic gnt0,
    output logic gnt1
);

    logic prefer1;

`ifdef DMEM_ARB_RR_EN
    // Priority pointer: after a grant, the other port is favoured on a tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prefer1 <= 1'b0;
        end else if (advance && (gnt0 || gnt1)) begin
            prefer1 <= gnt0;
        end
    end
`else
    // Fixed priority: port 0 is always favoured, so no pointer state exists.
    assign prefer1 = 1'b0;

    logic unused_rr;
    assign unused_rr = ^{clk, rst_n, advance};
`endif

    // Grant selection: one-hot or zero, never both ports.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && (!req1 || !prefer1)) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares one single-cycle data memory between the
// load/store stage (port 0) and the debug/loader port (port 1).
// Each transaction runs IDLE -> ACCESS -> RESP, or IDLE -> RESP when the
// address is misaligned or out of range, so memory is never touched by an
// errored access.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration;
// otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 51
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        mem_ce,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    import dmem_arb_pkg::*;

    state_t      state;
    state_t      state_nxt;

    logic        gnt0;
    logic        gnt1;
    logic        take;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_port;
    logic        lat_err;

    // A new transaction is accepted only while idle.
    assign take = (state == IDLE) && (req0 || req1);

    arb2 u_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .advance (take),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    // Winner payload mux and its address check.
    always_comb begin
        sel_we    = gnt1 ? we1    : we0;
        sel_addr  = gnt1 ? addr1  : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
        sel_err   = addr_err(sel_addr, MEM_BYTES);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = sel_err ? RESP : ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Payload latch at grant time and read-data capture at the end of ACCESS;
    // later payload changes by the requester are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_port  <= 1'b0;
            lat_err   <= 1'b0;
            rdata     <= '0;
        end else begin
            if (take) begin
                lat_we    <= sel_we;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                lat_port  <= gnt1;
                lat_err   <= sel_err;
            end
            if (state == ACCESS) begin
                rdata <= lat_we ? 32'h0 : mem_rdata;
            end
        end
    end

    // Memory controls only in ACCESS; ack/err only in RESP, to the winner.
    always_comb begin
        mem_ce       = 1'b0;
        mem_memwrite = 1'b0;
        mem_memread  = 1'b0;
        mem_addr     = '0;
        mem_wrdata   = '0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        err0         = 1'b0;
        err1         = 1'b0;
        unique case (state)
            ACCESS: begin
                mem_ce       = 1'b1;
                mem_memwrite = lat_we;
                mem_memread  = !lat_we;
                mem_addr     = lat_addr;
                mem_wrdata   = lat_wdata;
            end
            RESP: begin
                ack0 = !lat_port;
                ack1 = lat_port;
                err0 = !lat_port && lat_err;
                err1 = lat_port && lat_err;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 51, number of bytes in the attached data memory.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  synchronous reset, active low.
REQ-004 SHALL have ports req0/req1  in  1  access request from requester 0 (load/store stage) / 1 (debug/loader).
REQ-005 SHALL have ports we0/we1  in  1  1 = word write, 0 = word read.
REQ-006 SHALL have ports addr0/addr1  in  32  byte address.
REQ-007 SHALL have ports wdata0/wdata1  in  32  write word, big-endian.
REQ-008 SHALL have ports ack0/ack1  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports err0/err1  out  1  error flag, valid only with ack.
REQ-010 SHALL have port rdata  out  32  read word, valid with ack.
REQ-011 SHALL have ports mem_ce, mem_memwrite, mem_memread  out  1  memory controls.
REQ-012 SHALL have ports mem_addr, mem_wrdata  out  32  memory address/data.
REQ-013 SHALL have port mem_rdata  in  32  combinational read word from memory.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; error path IDLE -> RESP.
REQ-016 IDLE: if any req high, SHALL select a winner, latch its we/addr/wdata, and go to ACCESS (or to RESP with error flag set).
REQ-017 Error SHALL be addr[1:0] != 0 or addr+3 >= MEM_BYTES; errored transactions SHALL NOT touch memory.
REQ-018 ACCESS: SHALL drive mem_ce=1, mem_addr/mem_wrdata from latched values, mem_memwrite=we, mem_memread=!we, for exactly one cycle.
REQ-019 In ACCESS, SHALL capture mem_rdata into rdata at cycle end for reads; for writes, rdata SHALL be 0.
REQ-020 RESP: SHALL pulse ack of the winner only, err as computed; rdata held until next RESP.
REQ-021 Latency: req sampled in IDLE at cycle N -> ack at N+2 (N+1 for errors); maximum throughput is 1 transaction per 3 cycles.
REQ-022 Outside ACCESS, mem_ce, mem_memwrite and mem_memread SHALL be 0.
REQ-023 Requester SHALL hold req and payload stable until ack, then drop req; a req still high in IDLE after ack is a new request.
REQ-024 Payload changes after the IDLE latch edge SHALL NOT affect the current transaction.
REQ-025 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-026 rst_n low at a clock edge SHALL force IDLE, clear the latched payload, rdata, ack/err, mem controls, and busy to 0, and reset the priority pointer to favour port 0.
REQ-027 Reset during ACCESS SHALL drop the transaction: no ack; mem_memwrite SHALL be 0 from the next cycle.

Configuration
REQ-028 With DMEM_ARB_RR_EN defined, SHALL round-robin: on simultaneous requests, grant the port not granted last; the pointer updates on each grant, including error grants.
REQ-029 Without DMEM_ARB_RR_EN, SHALL use fixed priority: port 0 always wins simultaneous requests, and the pointer logic is absent.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold the FSM state enum and the alignment/bounds error-check constants.
REQ-031 Winner selection SHALL be a sub-module arb2 (two-way arbiter with optional RR pointer); the memory itself is external.

Verification
REQ-032 Write port0 addr=8, wdata=0x11223344, then read addr=8 -> ack0 at N+2 for both; read returns rdata=0x11223344, err0=0.
REQ-033 req0 and req1 both high from reset with RR -> grant order 0,1,0,1; without RR -> port 0 is served continuously while req0 stays high.
REQ-034 Read addr=6 (misaligned) or addr=48 (48+3 >= 51) -> ack at N+1 with err=1; mem_ce stays 0 throughout.
REQ-035 rst_n low during ACCESS of a write to addr=4 -> no ack; FSM in IDLE and mem_memwrite=0 from the next cycle.
REQ-036 Change addr1 during ACCESS -> mem_addr keeps the latched value; ack1 and rdata match the original address.
